axi_req_arbiter: RTL
====================

// Module: axi_req_arbiter
// PURPOSE
//  Shares the single-outstanding AXI master driver between NUM_REQ cache-side requesters
//  (port 0 = dirty-line writeback, port 1 = line refill, extra ports = uncached I/O).
//  Picks one request, presents it on the driver front-end, and routes the response back
//  to the owner. Only then does it accept another request. A watchdog aborts hung transactions.
// PARAMETERS
//  AXI_ADDR_WIDTH  32  address width
//  AXI_DATA_WIDTH  64  data width; strobe width = AXI_DATA_WIDTH/8
//  NUM_REQ         2   number of requesters, >=2; OWN_W = $clog2(NUM_REQ)
//  ARB_MODE        0   0 = round-robin, 1 = fixed priority (lowest index wins)
//  TIMEOUT_CYCLES  1024  max cycles between driver responses in WAIT_RSP; 0 disables watchdog
// PORTS
//  M_AXI_ACLK     in   1            clock
//  M_AXI_ARESETN  in   1            async active-low reset
//  rq_valid       in   NUM_REQ      per-requester request valid
//  rq_is_write    in   NUM_REQ      1 = write, 0 = read
//  rq_addr        in   NUM_REQ*AW   flattened addresses, port i at [i*AW +: AW]
//  rq_len         in   NUM_REQ*8    beats-1 per port
//  rq_size        in   NUM_REQ*3    AxSIZE per port
//  rq_wdata       in   NUM_REQ*DW   single-beat write data per port
//  rq_wstrb       in   NUM_REQ*DW/8 write strobes per port
//  rq_ready       out  NUM_REQ      grant/accept, one-hot or zero
//  rsp_valid      out  NUM_REQ      response beat to owner, one-hot or zero
//  rsp_rdata      out  DW           read data, shared by all ports
//  rsp_err        out  1            slave error (BRESP/RRESP != OKAY) or timeout
//  rsp_last       out  1            final beat of the transaction
//  timeout_flag   out  1            sticky; set on any watchdog abort, cleared only by reset
//  drv_req_valid/drv_req_ready  out/in 1   driver front-end handshake
//  drv_req_is_write,drv_req_addr,drv_req_len,drv_req_size,drv_req_wdata,drv_req_wstrb  out  as rq_*
//  drv_rsp_valid  in   1            driver response beat (B or R)
//  drv_rsp_rdata  in   DW           R data
//  drv_rsp_err    in   1            response error
//  drv_rsp_last   in   1            RLAST; ignored for writes
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NUM_REQ-1, all outputs 0, latched request regs 0, wdog=0.
//  FSM IDLE -> ISSUE -> WAIT_RSP -> IDLE. There is exactly one transaction in flight.
//  IDLE
//   - grant = arbitrate(rq_valid). rq_ready = grant, combinational, only in IDLE.
//   - RR: search starts at rr_ptr+1 mod NUM_REQ. Fixed: lowest set index.
//   - On rq_valid&rq_ready: latch fields and owner index, go to ISSUE.
//  ISSUE
//   - drv_req_valid=1 with latched fields, held stable until drv_req_ready.
//   - The handshake cycle moves to WAIT_RSP and clears wdog.
//  WAIT_RSP
//   - Each drv_rsp_valid drives rsp_valid[owner]=1 in the same cycle (combinational pass-through).
//     rsp_rdata/rsp_err follow the driver.
//   - Write: the first drv_rsp_valid completes the transaction, with rsp_last forced to 1.
//   - Read: completes on drv_rsp_valid&drv_rsp_last; rsp_last = drv_rsp_last.
//   - On completion: rr_ptr<=owner, go to IDLE. The next grant is possible the following cycle.
//  Requester rules
//   - Must hold rq_valid and its fields stable until rq_ready.
//   - No rsp back-pressure: the owner must sink every beat.
//  Watchdog: wdog counts cycles in WAIT_RSP and clears on every drv_rsp_valid.
//   - When wdog reaches TIMEOUT_CYCLES-1 with no drv_rsp_valid that cycle:
//     rsp_valid[owner]=1, rsp_err=1, rsp_last=1, timeout_flag<=1, go to IDLE.
//   - Late driver beats after an abort are dropped, i.e. drv_rsp_valid is ignored outside WAIT_RSP.
//  Boundary cases
//   - drv_rsp_valid in the same cycle as expiry: the real beat wins and the counter clears.
//   - A request arriving during ISSUE or WAIT_RSP waits, with rq_ready=0.
//   - A single requester valid wins regardless of rr_ptr.
//   - Reset mid-transaction: immediate return to the reset state; no response is emitted.
//  Widths: wdog is $clog2(TIMEOUT_CYCLES+1) bits, saturating. Owner is OWN_W bits.
// STRUCTURE
//  axi_cache_pkg holds:
//   - arb_state_e {IDLE,ISSUE,WAIT_RSP}
//   - ARB_RR/ARB_FIXED constants
//   - AXI_RESP_OKAY and AXI_BURST_INCR constants
//  Sub-module rr_arbiter (NUM_REQ, MODE): req vector + rr_ptr -> one-hot grant + index.
//   It is purely combinational; the pointer register lives in axi_req_arbiter.
// TESTING
//  1. Read: port1 rq addr=0x1000 len=0 -> drv_req_addr=0x1000, is_write=0.
//     Then drv_rsp data=0xDEAD_BEEF last=1 -> rsp_valid=2'b10, rsp_rdata=0xDEAD_BEEF, rsp_last=1.
//  2. RR fairness: both ports valid continuously after reset, 4 txns -> grant order 0,1,0,1.
//     With ARB_MODE=1 -> 0,0,0,0.
//  3. Back-pressure: hold drv_req_ready=0 for 5 cycles -> drv_req_* stable, rq_ready=0 throughout.
//  4. Burst: port1 read len=3, 4 beats, last on 4th -> 4 rsp_valid pulses, rsp_last only on 4th.
//     The next grant is possible the cycle after.
//  5. Timeout: TIMEOUT_CYCLES=16, write, no drv_rsp -> rsp_valid[0], rsp_err=1 at the 16th WAIT_RSP cycle.
//     timeout_flag stays 1 after further transactions.
//  6. Reset during WAIT_RSP -> all outputs 0 immediately.
//     After release, port0 write 0x2000 is granted normally and completes with a BRESP error -> rsp_err=1.

Source files
------------

// File: rtl/axi_cache_pkg.sv
// Shared types and constants for the cache-side AXI request arbiter.
package axi_cache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_req_arbiter_if.sv
// Front-end handshake between the request arbiter and the single-outstanding AXI driver.
interface axi_req_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
);
    logic                        drv_req_valid;
    logic                        drv_req_ready;
    logic                        drv_req_is_write;
    logic [AXI_ADDR_WIDTH-1:0]   drv_req_addr;
    logic [7:0]                  drv_req_len;
    logic [2:0]                  drv_req_size;
    logic [AXI_DATA_WIDTH-1:0]   drv_req_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] drv_req_wstrb;
    logic                        drv_rsp_valid;
    logic [AXI_DATA_WIDTH-1:0]   drv_rsp_rdata;
    logic                        drv_rsp_err;
    logic                        drv_rsp_last;

    modport master (
        output drv_req_valid, drv_req_is_write, drv_req_addr, drv_req_len,
               drv_req_size, drv_req_wdata, drv_req_wstrb,
        input  drv_req_ready, drv_rsp_valid, drv_rsp_rdata, drv_rsp_err, drv_rsp_last
    );

    modport slave (
        input  drv_req_valid, drv_req_is_write, drv_req_addr, drv_req_len,
               drv_req_size, drv_req_wdata, drv_req_wstrb,
        output drv_req_ready, drv_rsp_valid, drv_rsp_rdata, drv_rsp_err, drv_rsp_last
    );
endinterface

// File: rtl/axi_req_arbiter_rr_arbiter.sv
// Combinational requester picker: round-robin from ptr+1, or fixed lowest-index priority.
module rr_arbiter
    import axi_cache_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MODE    = ARB_RR,
    parameter int OWN_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWN_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [OWN_W-1:0]   idx
);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (MODE == ARB_FIXED) begin
                cand = k;
            end else begin
                cand = (int'(ptr) + 1 + k) % NUM_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = OWN_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares one single-outstanding AXI driver between NUM_REQ requesters, with response routing and a watchdog.
module axi_req_arbiter
    import axi_cache_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int NUM_REQ        = 2,
    parameter int ARB_MODE       = ARB_RR,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                    M_AXI_ACLK,
    input  logic                                    M_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]                      rq_valid,
    input  logic [NUM_REQ-1:0]                      rq_is_write,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]       rq_addr,
    input  logic [NUM_REQ*8-1:0]                    rq_len,
    input  logic [NUM_REQ*3-1:0]                    rq_size,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]       rq_wdata,
    input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0]     rq_wstrb,
    output logic [NUM_REQ-1:0]                      rq_ready,
    output logic [NUM_REQ-1:0]                      rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                    rsp_err,
    output logic                                    rsp_last,
    output logic                                    timeout_flag,
    axi_req_arbiter_if.master                       drv
);

    localparam int AW     = AXI_ADDR_WIDTH;
    localparam int DW     = AXI_DATA_WIDTH;
    localparam int SW     = AXI_DATA_WIDTH / 8;
    localparam int OWN_W  = $clog2(NUM_REQ);
    localparam int WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        (TIMEOUT_CYCLES > 0) ? WDOG_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT_RSP;

    logic [1:0]         state;
    logic [OWN_W-1:0]   rr_ptr;
    logic [OWN_W-1:0]   owner;
    logic [OWN_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               lat_is_write;
    logic [AW-1:0]      lat_addr;
    logic [7:0]         lat_len;
    logic [2:0]         lat_size;
    logic [DW-1:0]      lat_wdata;
    logic [SW-1:0]      lat_wstrb;
    logic [WDOG_W-1:0]  wdog;
    logic               beat;
    logic               expire;
    logic               done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .MODE    (ARB_MODE),
        .OWN_W   (OWN_W)
    ) u_arb (
        .req   (rq_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign drv.drv_req_valid    = (state == ST_ISSUE);
    assign drv.drv_req_is_write = lat_is_write;
    assign drv.drv_req_addr     = lat_addr;
    assign drv.drv_req_len      = lat_len;
    assign drv.drv_req_size     = lat_size;
    assign drv.drv_req_wdata    = lat_wdata;
    assign drv.drv_req_wstrb    = lat_wstrb;

    // Driver beats only count while waiting; late beats after an abort fall on the floor.
    assign beat   = (state == ST_WAIT) && drv.drv_rsp_valid;
    assign expire = (TIMEOUT_CYCLES > 0) && (state == ST_WAIT) && !drv.drv_rsp_valid &&
                    (wdog == WDOG_LAST);
    assign done   = expire || (beat && (lat_is_write || drv.drv_rsp_last));

    always_comb begin
        rq_ready  = (M_AXI_ARESETN && state == ST_IDLE) ? grant : '0;
        rsp_valid = '0;
        if (beat || expire) begin
            rsp_valid[owner] = 1'b1;
        end
        rsp_rdata = beat ? drv.drv_rsp_rdata : '0;
        rsp_err   = beat ? drv.drv_rsp_err : expire;
        rsp_last  = beat ? (lat_is_write | drv.drv_rsp_last) : expire;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state        <= ST_IDLE;
            rr_ptr       <= OWN_W'(NUM_REQ - 1);
            owner        <= '0;
            lat_is_write <= 1'b0;
            lat_addr     <= '0;
            lat_len      <= '0;
            lat_size     <= '0;
            lat_wdata    <= '0;
            lat_wstrb    <= '0;
            wdog         <= '0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner        <= grant_idx;
                        lat_is_write <= rq_is_write[grant_idx];
                        lat_addr     <= rq_addr[grant_idx*AW +: AW];
                        lat_len      <= rq_len[grant_idx*8 +: 8];
                        lat_size     <= rq_size[grant_idx*3 +: 3];
                        lat_wdata    <= rq_wdata[grant_idx*DW +: DW];
                        lat_wstrb    <= rq_wstrb[grant_idx*SW +: SW];
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (drv.drv_req_ready) begin
                        wdog  <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (beat) begin
                        wdog <= '0;
                    end else if (wdog != '1) begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                    if (expire) begin
                        timeout_flag <= 1'b1;
                    end
                    if (done) begin
                        rr_ptr <= owner;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
